// File: rtl/io_uart_tx_fifo.sv
// io_uart_tx_fifo: memory-mapped UART transmitter for the SOC IO page.
// A circular TX FIFO feeds a start/data/stop shifter. The baud divisor can be
// changed at run time and is sampled once per frame. A status word reports
// the FIFO state.
//
// state  | meaning
// IDLE   | line high; pops the FIFO head as soon as one is queued
// START  | start bit, line low for D clocks
// DATA   | DATA_BITS data bits, LSB first, D clocks each
// STOP   | line high for STOP_BITS*D clocks, then back to IDLE
module io_uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = 16,
    parameter int DIV_RESET = 104
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_wstrb,
    input  logic        i_rstrb,
    output logic [31:0] o_rdata,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]       PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]     BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       level;
    logic                 full;
    logic                 empty;

    // bus qualification
    logic                 wr_en;
    logic                 rd_en;
    logic                 push_req;
    logic                 push_ok;
    logic                 pop;

    // control/status registers
    logic                 ovf_q, ovf_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [31:0]          status;
    logic [31:0]          rdata_q, rdata_d;

    // transmit engine
    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
    logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
    logic                 baud_tc;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;

    // Only the low bits of the write bus reach any register.
    logic                 unused_wdata;
    assign unused_wdata = ^i_wdata;

    assign wr_en    = i_sel & i_wstrb;
    assign rd_en    = i_sel & i_rstrb;
    assign push_req = wr_en && (i_addr == ADDR_DATA);

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A full FIFO still takes a push when the shifter drains the head in the same cycle.
    assign push_ok = push_req && (!full || pop);

    assign div_eff = (div_q == '0) ? DIV_ONE : div_q;
    assign baud_tc = (baud_cnt_q == '0);

    // pointer advance, overflow flag and divisor register next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (wr_en && (i_addr == ADDR_STATUS) && i_wdata[3]) begin
            ovf_d = 1'b0;
        end
        if (wr_en && (i_addr == ADDR_DIV)) begin
            div_d = i_wdata[DIV_WIDTH-1:0];
        end
    end

    // frame sequencer: down-counter per bit period, terminal count advances the state
    always_comb begin
        state_d    = state_q;
        div_lat_d  = div_lat_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q[PTR_W-1:0]];
                    div_lat_d  = div_eff;
                    baud_cnt_d = div_eff - DIV_ONE;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_tc) begin
                    state_d    = ST_DATA;
                    bit_idx_d  = '0;
                    baud_cnt_d = div_lat_q - DIV_ONE;
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end
            end
            ST_DATA: begin
                if (baud_tc) begin
                    baud_cnt_d = div_lat_q - DIV_ONE;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end
            end
            default: begin
                if (baud_tc) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                        baud_cnt_d = div_lat_q - DIV_ONE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end
            end
        endcase
    end

    // line level for the current state; registered so o_tx is glitch-free
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // status word assembly; bit 9 mirrors full for legacy pollers
    always_comb begin
        status        = '0;
        status[0]     = full;
        status[1]     = empty;
        status[2]     = (state_q != ST_IDLE) || !empty;
        status[3]     = ovf_q;
        status[9]     = full;
        status[23:16] = 8'(level);
    end

    // read mux; the result is held until the next read
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (i_addr)
                ADDR_STATUS: rdata_d = status;
                ADDR_DIV:    rdata_d = 32'(div_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    // FIFO storage write; contents need no reset because the pointers define validity
    always_ff @(posedge i_clk) begin
        if (!i_rst && push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= i_wdata[DATA_BITS-1:0];
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            div_q      <= DIV_WIDTH'(DIV_RESET);
            rdata_q    <= '0;
            state_q    <= ST_IDLE;
            div_lat_q  <= DIV_ONE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            div_lat_q  <= div_lat_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_tx    = tx_q;
    assign o_irq   = empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_io_uart_tx_fifo.sv
// Testbench for io_uart_tx_fifo: register access, serial framing, FIFO limits,
// divisor changes and reset during a frame.
module tb_io_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        wstrb;
    logic        rstrb;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic       wave_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    io_uart_tx_fifo #(
        .DEPTH(16), .DATA_BITS(8), .STOP_BITS(1), .DIV_WIDTH(16), .DIV_RESET(104)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_addr(addr), .i_wdata(wdata),
        .i_wstrb(wstrb), .i_rstrb(rstrb), .o_rdata(rdata), .o_tx(tx), .o_irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // All bus tasks start and end at a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wstrb = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; rstrb = 1'b1; addr = a;
        @(negedge clk);
        sel = 1'b0; rstrb = 1'b0;
        d = rdata;
    endtask

    // Expected line samples of one 8N1 frame at d clocks per bit.
    task automatic push_wave(input logic [7:0] b, input int d);
        for (int i = 0; i < d; i++) wave_q.push_back(1'b0);
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < d; i++) wave_q.push_back(b[j]);
        for (int i = 0; i < d; i++) wave_q.push_back(1'b1);
    endtask

    // Samples one frame mid-bit; ok=0 on timeout or bad stop bit.
    task automatic rx_byte(input int d, output logic [7:0] b, output bit ok);
        int w;
        w = 0; b = '0; ok = 1'b0;
        while (tx !== 1'b0 && w < 40 * d + 50) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) return;
        repeat (d + d / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b[i] = tx;
            repeat (d) @(negedge clk);
        end
        ok = (tx === 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b want 1", irq); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        bus_read(2'd1, r);
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status: got %h want 00000002", r); end
        bus_read(2'd2, r);
        n_checks++; if (r !== 32'd104) begin n_fail++; $display("FAIL reset_divisor: got %0d want 104", r); end
        bus_read(2'd0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL data_read_zero: got %h want 0", r); end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h want 0", r); end
        bus_read(2'd1, r);
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL reserved_write_ignored: got %h want 00000002", r); end
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        logic        exp_tx;
        logic        exp_irq;
        int          d;
        d = 4;
        bus_write(2'd2, 32'd4);
        bus_read(2'd2, r);
        n_checks++; if (r !== 32'd4) begin n_fail++; $display("FAIL divisor_rw: got %0d want 4", r); end
        wave_q.delete();
        wave_q.push_back(1'b1);
        wave_q.push_back(1'b1);
        push_wave(8'h55, d);
        bus_write(2'd0, 32'h0000_0155);
        for (int k = 0; k < 10 * d + 5; k++) begin
            exp_tx  = (wave_q.size() > 0) ? wave_q.pop_front() : 1'b1;
            exp_irq = (k >= 1 + 10 * d);
            n_checks++;
            if (tx !== exp_tx) begin n_fail++; $display("FAIL single_tx[%0d]: got %b want %b", k, tx, exp_tx); end
            n_checks++;
            if (irq !== exp_irq) begin n_fail++; $display("FAIL single_irq[%0d]: got %b want %b", k, irq, exp_irq); end
            @(negedge clk);
        end
        bus_read(2'd1, r);
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL single_status_end: got %h want 00000002", r); end
    endtask

    task automatic test_divisor_zero();
        logic exp_tx;
        bus_write(2'd2, 32'd0);
        wave_q.delete();
        wave_q.push_back(1'b1);
        wave_q.push_back(1'b1);
        push_wave(8'hC6, 1);
        bus_write(2'd0, 32'h0000_00C6);
        for (int k = 0; k < 15; k++) begin
            exp_tx = (wave_q.size() > 0) ? wave_q.pop_front() : 1'b1;
            n_checks++;
            if (tx !== exp_tx) begin n_fail++; $display("FAIL div0_tx[%0d]: got %b want %b", k, tx, exp_tx); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_divisor_change();
        logic [31:0] r;
        logic        exp_tx;
        bus_write(2'd2, 32'd8);
        wave_q.delete();
        wave_q.push_back(1'b1);
        wave_q.push_back(1'b1);
        push_wave(8'hA3, 8);
        wave_q.push_back(1'b1);
        push_wave(8'h5C, 2);
        sel = 1'b1; wstrb = 1'b1; addr = 2'd0; wdata = 32'h0000_00A3;
        @(negedge clk);
        for (int k = 0; k < 2 + 80 + 1 + 20 + 4; k++) begin
            exp_tx = (wave_q.size() > 0) ? wave_q.pop_front() : 1'b1;
            n_checks++;
            if (tx !== exp_tx) begin n_fail++; $display("FAIL b2b_tx[%0d]: got %b want %b", k, tx, exp_tx); end
            if (k == 0) begin
                wdata = 32'h0000_005C;
            end else if (k == 1) begin
                sel = 1'b0; wstrb = 1'b0;
            end else if (k == 35) begin
                sel = 1'b1; wstrb = 1'b1; addr = 2'd2; wdata = 32'd2;
            end else if (k == 36) begin
                sel = 1'b0; wstrb = 1'b0;
            end
            @(negedge clk);
        end
        bus_read(2'd2, r);
        n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL b2b_divisor: got %0d want 2", r); end
    endtask

    task automatic test_full_fifo_collision();
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  e;
        bit          ok;
        int          t;
        int          p;
        int          d;
        d = 20;
        bus_write(2'd2, 32'd20);
        exp_q.delete();
        rx_q.delete();
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    rx_byte(d, b, ok);
                    if (!ok) break;
                    rx_q.push_back(b);
                end
            end
            begin
                t = cyc + 1;
                p = t + 2 + 10 * d;
                exp_q.push_back(8'hFF);
                bus_write(2'd0, 32'h0000_00FF);
                for (int i = 0; i <= 16; i++) begin
                    if (i < 16) exp_q.push_back(8'(i));
                    bus_write(2'd0, 32'(i));
                end
                bus_read(2'd1, r);
                n_checks++; if (r !== 32'h0010_020D) begin n_fail++; $display("FAIL full_status: got %h want 0010020d", r); end
                bus_write(2'd1, 32'h0000_0008);
                bus_read(2'd1, r);
                n_checks++; if (r !== 32'h0010_0205) begin n_fail++; $display("FAIL ovf_clear: got %h want 00100205", r); end
                n_checks++;
                if (cyc >= p - 1) begin
                    n_fail++; $display("FAIL collision_setup: cycle %0d reached, want below %0d", cyc, p - 1);
                end
                while (cyc < p - 1) @(negedge clk);
                exp_q.push_back(8'h20);
                bus_write(2'd0, 32'h0000_0020);
                bus_read(2'd1, r);
                n_checks++; if (r !== 32'h0010_0205) begin n_fail++; $display("FAIL collision_status: got %h want 00100205", r); end
            end
        join
        n_checks++;
        if (rx_q.size() != 18) begin n_fail++; $display("FAIL full_rx_count: got %0d want 18", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            b = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (b !== e) begin n_fail++; $display("FAIL full_rx_byte: got %h want %h", b, e); end
        end
        repeat (2 * d) @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL full_irq_end: got %b want 1", irq); end
        bus_read(2'd1, r);
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL full_status_end: got %h want 00000002", r); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        logic        exp_tx;
        bus_write(2'd2, 32'd4);
        wave_q.delete();
        wave_q.push_back(1'b1);
        wave_q.push_back(1'b1);
        push_wave(8'h0F, 4);
        sel = 1'b1; wstrb = 1'b1; addr = 2'd0; wdata = 32'h0000_000F;
        @(negedge clk);
        for (int k = 0; k <= 26; k++) begin
            exp_tx = (wave_q.size() > 0) ? wave_q.pop_front() : 1'b1;
            n_checks++;
            if (tx !== exp_tx) begin n_fail++; $display("FAIL rstmid_tx[%0d]: got %b want %b", k, tx, exp_tx); end
            if (k == 0) wdata = 32'h0000_0000;
            if (k == 1) begin sel = 1'b0; wstrb = 1'b0; end
            if (k < 26) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_after: got %b want 1", tx); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rstmid_irq: got %b want 1", irq); end
        bus_read(2'd1, r);
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL rstmid_status: got %h want 00000002", r); end
        bus_read(2'd2, r);
        n_checks++; if (r !== 32'd104) begin n_fail++; $display("FAIL rstmid_divisor: got %0d want 104", r); end
        for (int k = 0; k < 60; k++) begin
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_residual[%0d]: got %b want 1", k, tx); end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d, want completion earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; addr = 2'd0; wdata = '0; wstrb = 1'b0; rstrb = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_divisor_zero();
        test_back_to_back_divisor_change();
        test_full_fifo_collision();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
